seg_digit_display: RTL and testbench
====================================

# seg_digit_display

Multi-digit, frame-synchronous decimal renderer for the VGA pipeline. It accepts a binary value through a valid/ready handshake and converts it to BCD with an iterative double-dabble engine. At the next frame start it commits the result to a shadow register, then draws the digits as scalable seven-segment glyphs from the beam coordinates through a 2-stage registered pixel pipeline. The block sits between the score/counter logic and the VGA colour mux; it adds leading-zero blanking, overflow indication and blinking.

## Interface
- NUM_DIGITS, 4: digits drawn, 1..6; digit 0 is least significant and rightmost.
- VALUE_W, 14: binary input width, 1..20.
- DIGIT_W, 60: glyph width in pixels.
- DIGIT_H, 100: glyph height in pixels; must be even.
- LINE_W, 20: stroke width in pixels; must be even and ≤ DIGIT_H/2.
- DIGIT_GAP, 20: horizontal gap between glyphs; PITCH = DIGIT_W + DIGIT_GAP.
- BLINK_FRAMES, 30: frames per blink half-period, ≥1.
- clk, in, 1: pixel clock.
- rst_n, in, 1: asynchronous, active-low reset.
- x, in, 10: current beam X.
- y, in, 10: current beam Y.
- base_x, in, 10: left edge of the leftmost digit (digit NUM_DIGITS-1).
- base_y, in, 10: top edge of all digits.
- frame_start, in, 1: one-cycle pulse at the start of each frame.
- value_in, in, VALUE_W: binary value to display.
- value_valid, in, 1: value_in is offered.
- value_ready, out, 1: the block can accept a value.
- blank_lz, in, 1: blank leading zeros.
- blink_en, in, 1: enable blinking.
- pixel_out, out, 1: the pixel at (x,y) from 2 cycles earlier belongs to a lit segment.

## Operation
- **Handshake:** a value is accepted on a rising edge with value_valid && value_ready. Inputs are ignored while value_ready=0.
- **Overflow:** at accept, ovf is latched as value_in ≥ 10^NUM_DIGITS.
- **Converter FSM:**
  - IDLE: value_ready=1; on accept → CONV, loading the shift register and clearing the BCD accumulator.
  - CONV: one shift per cycle; before each shift, add 3 to every BCD nibble ≥5; a bit counter runs 0..VALUE_W-1. When the counter reaches VALUE_W-1 → DONE.
  - DONE: one cycle; copies BCD and ovf into pending and sets pending_flag → IDLE.
- **Pending register:** a new DONE while pending_flag=1 overwrites pending; latest value wins.
- **Commit:** on frame_start with pending_flag=1 (as registered before the edge), display ← pending and pending_flag is cleared. If the commit and DONE fall in the same cycle, the new value waits for the next frame_start.
- **Segment masks (per displayed digit):**
  - Standard a–g encoding; 1 = b,c and 7 = a,b,c.
  - If display ovf is set, every digit shows g only (dash).
  - If blank_lz=1, every digit above the highest nonzero digit is blank. Digit 0 is never blanked, so value 0 shows "0".
- **Glyph geometry (lx,ly relative to the digit origin):**
  - a: ly<LINE_W.
  - g: DIGIT_H/2−LINE_W/2 ≤ ly < DIGIT_H/2+LINE_W/2.
  - d: ly ≥ DIGIT_H−LINE_W.
  - f, b: ly<DIGIT_H/2; f at lx<LINE_W, b at lx ≥ DIGIT_W−LINE_W.
  - e, c: ly ≥ DIGIT_H/2, with the same lx limits as f and b.
  - Horizontal segments span the full DIGIT_W.
- **Digit selection:**
  - dx = x−base_x and dy = y−base_y, computed 11 bits wide; a negative result is outside the display.
  - Digit index k = NUM_DIGITS−1−j, where j·PITCH ≤ dx < j·PITCH+DIGIT_W.
  - j is found by parallel constant compares; no divider.
  - Gap columns and dy ≥ DIGIT_H are unlit.
- **Blink:**
  - A frame counter increments on frame_start and wraps at BLINK_FRAMES−1, toggling the phase bit on wrap.
  - When blink_en=1 and phase=1, pixel_out=0.
  - The counter and phase run regardless of blink_en.

## Timing
- **Reset values:** pixel_out=0, value_ready=1 (IDLE), display=0, ovf=0, pending_flag=0, frame counter=0, phase=0.
- **Reset mid-conversion:** the conversion is discarded.
- **Conversion latency:** pending_flag rises VALUE_W+1 cycles after the accept edge. value_ready is low for exactly VALUE_W+1 cycles.
- **Displayed-value latency:** visible from the first frame_start after pending_flag=1.
- **Pixel pipeline:**
  - Stage 1 registers dx, dy, the in-range flags, the digit index and lx, ly.
  - Stage 2 registers the segment hit ANDed with the mask and the blink gate.
  - pixel_out for (x,y) appears 2 cycles after x,y are presented, at full throughput of one pixel per cycle.
- **Same-cycle events:** frame_start together with an accept has no effect on the new value.

## Test plan
- **Basic render:** reset, accept 1234, pulse frame_start. Then:
  - Beam (base_x+85, base_y+5), which is digit 2 ("2"), segment a → pixel_out=1 two cycles later.
  - Beam (base_x+70, base_y+50), a gap column → 0.
- **Conversion timing:** accept 9999 → value_ready low for 15 cycles. Display is unchanged until frame_start; after it, all four digits show the full 8-segment minus e pattern of "9".
- **Leading zeros:** accept 7 with blank_lz=1 → digits 3..1 dark and digit 0 shows a,b,c. With blank_lz=0 → "0007". Accept 0 with blank_lz=1 → a single "0".
- **Overflow:** accept 10000 (NUM_DIGITS=4) → all digits show only g, e.g. pixel at (base_x+30, base_y+50)=1 and at (base_x+5, base_y+5)=0.
- **Latest-wins and same-cycle commit:** accept 5, then 6 before any frame_start → shows 6. DONE coinciding with frame_start → commit deferred one frame.
- **Blink and reset:**
  - blink_en=1, BLINK_FRAMES=2: glyph lit for 2 frames, dark for 2, repeating.
  - Assert rst_n low mid-CONV: pixel_out=0 and value_ready=1 immediately. After the next frame_start the display shows "0" (blank_lz=1).

Source files
------------

// File: rtl/seg_digit_display.sv
// Frame-synchronous decimal renderer: double-dabble BCD conversion, frame-aligned
// commit and a 2-stage seven-segment pixel pipeline with blanking, overflow and blink.
module seg_digit_display #(
    parameter int NUM_DIGITS   = 4,
    parameter int VALUE_W      = 14,
    parameter int DIGIT_W      = 60,
    parameter int DIGIT_H      = 100,
    parameter int LINE_W       = 20,
    parameter int DIGIT_GAP    = 20,
    parameter int BLINK_FRAMES = 30
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    input  logic [9:0]         base_x,
    input  logic [9:0]         base_y,
    input  logic               frame_start,
    input  logic [VALUE_W-1:0] value_in,
    input  logic               value_valid,
    output logic               value_ready,
    input  logic               blank_lz,
    input  logic               blink_en,
    output logic               pixel_out
);

    localparam int PITCH  = DIGIT_W + DIGIT_GAP;
    localparam int CONV_N = (VALUE_W * 3) / 10 + 1;
    localparam int BCD_N  = (CONV_N > NUM_DIGITS) ? CONV_N : NUM_DIGITS;
    localparam int BW     = 4 * BCD_N;
    localparam int DW     = 4 * NUM_DIGITS;
    localparam int CW     = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;
    localparam int KW     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FW     = $clog2(BLINK_FRAMES + 1);
    localparam logic [31:0] OVF_LIMIT = 32'(10 ** NUM_DIGITS);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

    function automatic logic [BW-1:0] add3(input logic [BW-1:0] b);
        logic [BW-1:0] r;
        r = b;
        for (int i = 0; i < BCD_N; i++) begin
            if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Segment bit order is {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [6:0] seg_hit(input logic [10:0] lx, input logic [10:0] ly);
        logic [6:0] r;
        logic       top, left, right;
        top   = ly < 11'(DIGIT_H / 2);
        left  = lx < 11'(LINE_W);
        right = lx >= 11'(DIGIT_W - LINE_W);
        r[0]  = ly < 11'(LINE_W);
        r[1]  = top && right;
        r[2]  = !top && right;
        r[3]  = ly >= 11'(DIGIT_H - LINE_W);
        r[4]  = !top && left;
        r[5]  = top && left;
        r[6]  = (ly >= 11'(DIGIT_H / 2 - LINE_W / 2)) && (ly < 11'(DIGIT_H / 2 + LINE_W / 2));
        return r;
    endfunction

    state_t              state_q, state_d;
    logic                ready_q, ready_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [VALUE_W-1:0]  sh_q, sh_d;
    logic [BW-1:0]       bcd_q, bcd_d, bcd_adj;
    logic                ovf_q, ovf_d;
    logic                done;

    logic [DW-1:0]       pend_bcd_q, pend_bcd_d;
    logic                pend_ovf_q, pend_ovf_d;
    logic                pend_flag_q, pend_flag_d;
    logic [DW-1:0]       disp_bcd_q, disp_bcd_d;
    logic                disp_ovf_q, disp_ovf_d;
    logic                commit;

    logic [FW-1:0]       frame_cnt_q, frame_cnt_d;
    logic                phase_q, phase_d;

    logic signed [10:0]  dx, dy;
    int                  dxi, dyi;
    logic                vld_p1_q, vld_p1_d;
    logic [KW-1:0]       k_p1_q, k_p1_d;
    logic [10:0]         lx_p1_q, lx_p1_d, ly_p1_q, ly_p1_d;
    logic [6:0]          mask_p1;
    logic                pixel_p2_q, pixel_p2_d;

    assign bcd_adj     = add3(bcd_q);
    assign value_ready = ready_q;
    assign pixel_out   = pixel_p2_q;

    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (value_valid && ready_q) begin
                    state_d = S_CONV;
                    ready_d = 1'b0;
                    sh_d    = value_in;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = ({{(32 - VALUE_W){1'b0}}, value_in} >= OVF_LIMIT);
                end
            end
            S_CONV: begin
                bcd_d = {bcd_adj[BW-2:0], sh_q[VALUE_W-1]};
                sh_d  = sh_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(VALUE_W - 1)) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                done    = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // A DONE coinciding with a commit lands in pending and waits for the next frame.
    always_comb begin
        commit      = frame_start && pend_flag_q;
        pend_bcd_d  = done ? bcd_q[DW-1:0] : pend_bcd_q;
        pend_ovf_d  = done ? ovf_q : pend_ovf_q;
        pend_flag_d = done ? 1'b1 : (commit ? 1'b0 : pend_flag_q);
        disp_bcd_d  = commit ? pend_bcd_q : disp_bcd_q;
        disp_ovf_d  = commit ? pend_ovf_q : disp_ovf_q;
        frame_cnt_d = frame_cnt_q;
        phase_d     = phase_q;
        if (frame_start) begin
            if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
                frame_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    // Stage 1: beam offset, column select by constant compares, local glyph coordinates
    always_comb begin
        dx       = $signed({1'b0, x}) - $signed({1'b0, base_x});
        dy       = $signed({1'b0, y}) - $signed({1'b0, base_y});
        dxi      = int'(dx);
        dyi      = int'(dy);
        vld_p1_d = 1'b0;
        k_p1_d   = '0;
        lx_p1_d  = '0;
        ly_p1_d  = dy;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (dxi >= j * PITCH && dxi < j * PITCH + DIGIT_W) begin
                vld_p1_d = (dyi >= 0) && (dyi < DIGIT_H);
                k_p1_d   = KW'(NUM_DIGITS - 1 - j);
                lx_p1_d  = 11'(dxi - j * PITCH);
            end
        end
    end

    // Stage 2: digit mask, segment hit and blink gate
    always_comb begin
        if (disp_ovf_q)
            mask_p1 = 7'h40;
        else if (blank_lz && (k_p1_q != '0) && ((disp_bcd_q >> {k_p1_q, 2'b00}) == '0))
            mask_p1 = 7'h00;
        else
            mask_p1 = seg_decode(disp_bcd_q[k_p1_q*4 +: 4]);
        pixel_p2_d = vld_p1_q && (|(seg_hit(lx_p1_q, ly_p1_q) & mask_p1)) && !(blink_en && phase_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b1;
            pend_flag_q <= 1'b0;
            disp_bcd_q  <= '0;
            disp_ovf_q  <= 1'b0;
            frame_cnt_q <= '0;
            phase_q     <= 1'b0;
            vld_p1_q    <= 1'b0;
            pixel_p2_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            pend_flag_q <= pend_flag_d;
            disp_bcd_q  <= disp_bcd_d;
            disp_ovf_q  <= disp_ovf_d;
            frame_cnt_q <= frame_cnt_d;
            phase_q     <= phase_d;
            vld_p1_q    <= vld_p1_d;
            pixel_p2_q  <= pixel_p2_d;
        end
    end

    always_ff @(posedge clk) begin
        cnt_q      <= cnt_d;
        sh_q       <= sh_d;
        bcd_q      <= bcd_d;
        ovf_q      <= ovf_d;
        pend_bcd_q <= pend_bcd_d;
        pend_ovf_q <= pend_ovf_d;
        k_p1_q     <= k_p1_d;
        lx_p1_q    <= lx_p1_d;
        ly_p1_q    <= ly_p1_d;
    end

endmodule

// File: tb/tb_seg_digit_display.sv
// Randomized scoreboard bench for seg_digit_display against an arithmetic reference model.
module tb_seg_digit_display;

    localparam int ND = 4, VW = 14, DW = 60, DH = 100, LW = 20, GAP = 20, BF = 2;
    localparam int PITCH = DW + GAP;
    localparam int POW = 10 ** ND;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic [9:0]    x = '0, y = '0, bx = '0, by = '0;
    logic          fs = 1'b0, vv = 1'b0, blz = 1'b0, ben = 1'b0;
    logic [VW-1:0] vin = '0;
    logic          vr, pix;

    seg_digit_display #(
        .NUM_DIGITS(ND), .VALUE_W(VW), .DIGIT_W(DW), .DIGIT_H(DH),
        .LINE_W(LW), .DIGIT_GAP(GAP), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .base_x(bx), .base_y(by),
        .frame_start(fs), .value_in(vin), .value_valid(vv), .value_ready(vr),
        .blank_lz(blz), .blink_en(ben), .pixel_out(pix)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;

    // Reference model state: displayed/pending integers, busy flag, frame count.
    int m_disp = 0, m_pend = 0, m_new = 0, m_frames = 0, cyc = 0, done_at = -1;
    bit m_ovf = 0, m_povf = 0, m_flag = 0, m_ready = 1;

    typedef struct { int px; int py; bit v; } exp_t;
    exp_t q[$];
    bit bv = 0, bv1 = 0, bv2 = 0;

    function automatic string digit_segs(int d);
        case (d)
            0: return "abcdef";
            1: return "bc";
            2: return "abdeg";
            3: return "abcdg";
            4: return "bcfg";
            5: return "acdfg";
            6: return "acdefg";
            7: return "abc";
            8: return "abcdefg";
            9: return "abcdfg";
            default: return "";
        endcase
    endfunction

    function automatic bit seg_on(byte c, int lx, int ly);
        case (c)
            "a": return ly < LW;
            "b": return ly < DH / 2 && lx >= DW - LW;
            "c": return ly >= DH / 2 && lx >= DW - LW;
            "d": return ly >= DH - LW;
            "e": return ly >= DH / 2 && lx < LW;
            "f": return ly < DH / 2 && lx < LW;
            "g": return ly >= DH / 2 - LW / 2 && ly < DH / 2 + LW / 2;
            default: return 0;
        endcase
    endfunction

    function automatic bit ref_pixel(int px, int py, int pbx, int pby);
        int dx, dy, k;
        string segs;
        dx = px - pbx;
        dy = py - pby;
        if (dx < 0 || dy < 0 || dy >= DH) return 0;
        if (dx / PITCH >= ND || dx % PITCH >= DW) return 0;
        k = ND - 1 - dx / PITCH;
        if (ben && ((m_frames / BF) % 2 == 1)) return 0;
        if (m_ovf) segs = "g";
        else if (blz && k > 0 && m_disp < 10 ** k) segs = "";
        else segs = digit_segs((m_disp / (10 ** k)) % 10);
        for (int i = 0; i < segs.len(); i++)
            if (seg_on(segs[i], dx % PITCH, dy)) return 1;
        return 0;
    endfunction

    initial forever begin
        bit r0;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_disp = 0; m_ovf = 0; m_flag = 0; m_ready = 1;
            m_frames = 0; cyc = 0; done_at = -1;
        end else begin
            cyc++;
            r0 = m_ready;
            if (fs) begin
                if (m_flag) begin m_disp = m_pend; m_ovf = m_povf; m_flag = 0; end
                m_frames++;
            end
            if (cyc == done_at) begin
                m_pend = m_new; m_povf = (m_new >= POW); m_flag = 1;
                m_ready = 1; done_at = -1;
            end
            if (vv && r0) begin
                m_new = int'(vin); m_ready = 0; done_at = cyc + VW + 1;
            end
        end
    end

    always @(posedge clk) begin
        bv1 <= bv;
        bv2 <= bv1;
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        tests++;
        if (vr !== m_ready) begin
            fails++;
            $display("FAIL ready cyc=%0d got %b exp %b", cyc, vr, m_ready);
        end
        if (bv2) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL pix_underflow cyc=%0d got %b exp none", cyc, pix);
            end else begin
                e = q.pop_front();
                if (pix !== e.v) begin
                    fails++;
                    $display("FAIL pix x=%0d y=%0d disp=%0d got %b exp %b", e.px, e.py, m_disp, pix, e.v);
                end
            end
        end
    end

    task automatic chk(string name, int got, int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got %0d exp %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!m_ready && n < 100) begin tick(); n++; end
        chk("idle_timeout", int'(m_ready), 1);
    endtask

    task automatic send(int v);
        wait_idle();
        vin = VW'(v);
        vv = 1'b1;
        tick();
        repeat (3) begin vin = VW'($urandom); tick(); end
        vv = 1'b0;
    endtask

    task automatic frame();
        fs = 1'b1;
        tick();
        fs = 1'b0;
    endtask

    task automatic show(int v);
        send(v);
        wait_idle();
        frame();
    endtask

    task automatic put_pix(int ox, int oy);
        logic [9:0] px, py;
        px = 10'(int'(bx) + ox);
        py = 10'(int'(by) + oy);
        x = px;
        y = py;
        bv = 1'b1;
        q.push_back('{int'(px), int'(py), ref_pixel(int'(px), int'(py), int'(bx), int'(by))});
        tick();
    endtask

    task automatic drain();
        bv = 1'b0;
        repeat (3) tick();
    endtask

    task automatic scan_random(int n);
        bx = 10'($urandom_range(0, 500));
        by = 10'($urandom_range(0, 400));
        for (int i = 0; i < n; i++)
            put_pix(int'($urandom_range(0, 340)) - 10, int'($urandom_range(0, 120)) - 10);
        drain();
    endtask

    task automatic set_base();
        bx = 10'd100;
        by = 10'd50;
    endtask

    initial begin
        #3000000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pixel", int'(pix), 0);
        chk("reset_ready", int'(vr), 1);
        rst_n = 1'b1;
        tick();
        scan_random(20);

        show(1234);
        set_base();
        put_pix(85, 5);
        put_pix(70, 50);
        put_pix(5, 5);
        put_pix(265, 80);
        drain();
        scan_random(40);

        send(9999);
        wait_idle();
        scan_random(20);
        frame();
        scan_random(40);

        blz = 1'b1;
        show(7);
        set_base();
        put_pix(5, 5);
        put_pix(245, 5);
        put_pix(245, 30);
        put_pix(295, 80);
        drain();
        scan_random(30);
        blz = 1'b0;
        scan_random(30);
        blz = 1'b1;
        show(0);
        scan_random(40);

        blz = 1'b0;
        show(10000);
        set_base();
        put_pix(30, 50);
        put_pix(5, 5);
        drain();
        scan_random(30);

        send(5);
        send(6);
        wait_idle();
        frame();
        scan_random(30);

        send(42);
        begin
            int n = 0;
            while (cyc != done_at - 1 && n < 50) begin tick(); n++; end
            chk("align_timeout", int'(n < 50), 1);
        end
        frame();
        scan_random(30);
        frame();
        scan_random(30);

        show(1234);
        ben = 1'b1;
        for (int f = 0; f < 8; f++) begin
            frame();
            set_base();
            put_pix(85, 5);
            put_pix(265, 80);
            drain();
        end
        scan_random(20);
        ben = 1'b0;

        for (int i = 0; i < 25; i++) begin
            blz = 1'(($urandom_range(0, 1)));
            show(int'($urandom_range(0, 16383)));
            scan_random(30);
        end

        blz = 1'b1;
        show(8888);
        set_base();
        x = 10'd105;
        y = 10'd55;
        send(4321);
        repeat (4) tick();
        #1;
        rst_n = 1'b0;
        #1;
        chk("midconv_pixel", int'(pix), 0);
        chk("midconv_ready", int'(vr), 1);
        tick();
        rst_n = 1'b1;
        tick();
        frame();
        set_base();
        put_pix(245, 5);
        put_pix(225, 5);
        put_pix(5, 5);
        drain();
        scan_random(30);

        chk("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
